// File: rtl/ysyx_22040895_trap_ctrl_pkg.sv
// ysyx_22040895_trap_ctrl_pkg: trap sequencer states, mstatus bit positions and cause codes
package ysyx_22040895_trap_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        T_SAVE = 3'd1,
        T_STAT = 3'd2,
        T_JUMP = 3'd3,
        R_STAT = 3'd4,
        R_JUMP = 3'd5
    } state_e;

    localparam int         MIE_BIT        = 3;
    localparam int         MPIE_BIT       = 7;
    localparam int         MPP_LO         = 11;
    localparam int         MPP_HI         = 12;
    localparam logic [1:0] MPP_M          = 2'b11;
    localparam int         ECALL_M_CODE   = 11;
    localparam int         IRQ_TIMER_CODE = 7;

endpackage

// File: rtl/ysyx_22040895_mstatus_upd.sv
// ysyx_22040895_mstatus_upd: mstatus rewrite for trap entry (is_mret=0) and mret (is_mret=1)
module ysyx_22040895_mstatus_upd
    import ysyx_22040895_trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] mstatus_old,
    input  logic            is_mret,
    output logic [XLEN-1:0] mstatus_new
);

    // Trap stacks MIE into MPIE and masks; mret restores MIE from MPIE; both force MPP to machine mode
    always_comb begin
        mstatus_new                = mstatus_old;
        mstatus_new[MIE_BIT]       = is_mret ? mstatus_old[MPIE_BIT] : 1'b0;
        mstatus_new[MPIE_BIT]      = is_mret ? 1'b1 : mstatus_old[MIE_BIT];
        mstatus_new[MPP_HI:MPP_LO] = MPP_M;
    end

endmodule

// File: rtl/ysyx_22040895_trap_ctrl.sv
// ysyx_22040895_trap_ctrl: sequences ecall/mret (and timer IRQ when YSYX_22040895_TRAP_IRQ_EN is defined) into CSR accesses and a PC redirect
module ysyx_22040895_trap_ctrl
    import ysyx_22040895_trap_ctrl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int ECALL_CAUSE = ECALL_M_CODE
) (
    input  logic            clk,
    input  logic            rst,
`ifdef YSYX_22040895_TRAP_IRQ_EN
    input  logic            irq_timer_i,
`endif
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            set_mepc_o,
    output logic            set_mcause_o,
    output logic            set_mstatus_o,
    output logic            get_mepc_o,
    output logic            get_mtvec_o,
    output logic            get_mstatus_o,
    output logic [XLEN-1:0] wdata_mepc_o,
    output logic [XLEN-1:0] wdata_mcause_o,
    output logic [XLEN-1:0] wdata_mstatus_o,
    input  logic [XLEN-1:0] rdata_mepc_i,
    input  logic [XLEN-1:0] rdata_mtvec_i,
    input  logic [XLEN-1:0] rdata_mstatus_i
);

    localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-4){1'b0}}, 3'(IRQ_TIMER_CODE)};
    localparam logic [XLEN-1:0] TVEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_e          state, state_nxt;
    logic [XLEN-1:0] pc_q, cause_q, mstatus_new;
    logic            idle, take_irq, accept;

    // Requests are only seen in IDLE and never while reset is held
    assign idle = (state == IDLE) & rst;

`ifdef YSYX_22040895_TRAP_IRQ_EN
    assign take_irq = idle & irq_timer_i & rdata_mstatus_i[MIE_BIT];
`else
    assign take_irq = 1'b0;
`endif

    assign accept = idle & (take_irq | ecall_i | mret_i);

    ysyx_22040895_mstatus_upd #(.XLEN(XLEN)) u_mstatus_upd (
        .mstatus_old (rdata_mstatus_i),
        .is_mret     (state == R_STAT),
        .mstatus_new (mstatus_new)
    );

    // State register plus pc/cause latched at accept; async reset abandons a sequence mid-way
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pc_q    <= pc_i;
                cause_q <= take_irq ? IRQ_CAUSE : ecall_i ? XLEN'(ECALL_CAUSE) : '0;
            end
        end
    end

    // Next state and Moore decode; IRQ beats ecall beats mret, a losing mret stays pending
    always_comb begin
        state_nxt       = state;
        ready_o         = idle;
        busy_o          = state != IDLE;
        redirect_o      = 1'b0;
        redirect_pc_o   = '0;
        set_mepc_o      = 1'b0;
        set_mcause_o    = 1'b0;
        set_mstatus_o   = 1'b0;
        get_mepc_o      = 1'b0;
        get_mtvec_o     = 1'b0;
`ifdef YSYX_22040895_TRAP_IRQ_EN
        get_mstatus_o   = idle;
`else
        get_mstatus_o   = 1'b0;
`endif
        wdata_mepc_o    = '0;
        wdata_mcause_o  = '0;
        wdata_mstatus_o = '0;
        case (state)
            IDLE: state_nxt = (take_irq | ecall_i) ? T_SAVE : mret_i ? R_STAT : IDLE;
            T_SAVE: begin
                state_nxt      = T_STAT;
                set_mepc_o     = 1'b1;
                wdata_mepc_o   = pc_q;
                set_mcause_o   = 1'b1;
                wdata_mcause_o = cause_q;
            end
            T_STAT, R_STAT: begin
                state_nxt       = (state == T_STAT) ? T_JUMP : R_JUMP;
                get_mstatus_o   = 1'b1;
                set_mstatus_o   = 1'b1;
                wdata_mstatus_o = mstatus_new;
            end
            T_JUMP: begin
                state_nxt     = IDLE;
                get_mtvec_o   = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = rdata_mtvec_i & TVEC_MASK;
            end
            R_JUMP: begin
                state_nxt     = IDLE;
                get_mepc_o    = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = rdata_mepc_i;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22040895_trap_ctrl.sv
// tb_ysyx_22040895_trap_ctrl: randomized and directed checks of the trap sequencer against a transaction-level model
module tb_ysyx_22040895_trap_ctrl;

`ifdef YSYX_22040895_TRAP_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif
    localparam logic [63:0] IRQ_CAUSE = 64'h8000_0000_0000_0007;
    localparam logic [63:0] ECALL_C   = 64'd11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        irq_timer_i = 1'b0;
    logic        ecall_i = 1'b0, mret_i = 1'b0;
    logic [63:0] pc_i = '0;
    logic [63:0] rdata_mepc_i = '0, rdata_mtvec_i = '0, rdata_mstatus_i = '0;
    logic        ready_o, busy_o, redirect_o;
    logic [63:0] redirect_pc_o;
    logic        set_mepc_o, set_mcause_o, set_mstatus_o;
    logic        get_mepc_o, get_mtvec_o, get_mstatus_o;
    logic [63:0] wdata_mepc_o, wdata_mcause_o, wdata_mstatus_o;

    typedef struct packed {
        logic        ready;
        logic        busy;
        logic        redirect;
        logic [63:0] redirect_pc;
        logic        set_mepc;
        logic        set_mcause;
        logic        set_mstatus;
        logic        get_mepc;
        logic        get_mtvec;
        logic        get_mstatus;
        logic [63:0] wdata_mepc;
        logic [63:0] wdata_mcause;
        logic [63:0] wdata_mstatus;
    } obs_t;

    obs_t obs, e;
    int   n_cmp = 0, n_err = 0;

    assign obs = {ready_o, busy_o, redirect_o, redirect_pc_o, set_mepc_o, set_mcause_o, set_mstatus_o,
                  get_mepc_o, get_mtvec_o, get_mstatus_o, wdata_mepc_o, wdata_mcause_o, wdata_mstatus_o};

    ysyx_22040895_trap_ctrl dut (
        .clk             (clk),
        .rst             (rst),
`ifdef YSYX_22040895_TRAP_IRQ_EN
        .irq_timer_i     (irq_timer_i),
`endif
        .ecall_i         (ecall_i),
        .mret_i          (mret_i),
        .pc_i            (pc_i),
        .ready_o         (ready_o),
        .busy_o          (busy_o),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o),
        .set_mepc_o      (set_mepc_o),
        .set_mcause_o    (set_mcause_o),
        .set_mstatus_o   (set_mstatus_o),
        .get_mepc_o      (get_mepc_o),
        .get_mtvec_o     (get_mtvec_o),
        .get_mstatus_o   (get_mstatus_o),
        .wdata_mepc_o    (wdata_mepc_o),
        .wdata_mcause_o  (wdata_mcause_o),
        .wdata_mstatus_o (wdata_mstatus_o),
        .rdata_mepc_i    (rdata_mepc_i),
        .rdata_mtvec_i   (rdata_mtvec_i),
        .rdata_mstatus_i (rdata_mstatus_i)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic obs_t exp_idle();
        obs_t r = '0;
        r.ready       = 1'b1;
        r.get_mstatus = IRQ;
        return r;
    endfunction

    function automatic logic [63:0] ms_after(bit is_mret, logic [63:0] ms);
        logic [63:0] keep = ms & ~64'h1888;
        if (is_mret) return keep | (((ms >> 7) & 64'd1) << 3) | 64'h80 | 64'h1800;
        return keep | (((ms >> 3) & 64'd1) << 7) | 64'h1800;
    endfunction

    // Expected outputs for busy cycle 'step' of a trap (3 cycles) or mret (2 cycles) sequence
    function automatic obs_t exp_busy(bit is_mret, int step, logic [63:0] pc, logic [63:0] cause,
                                      logic [63:0] mtvec, logic [63:0] mepc, logic [63:0] ms);
        obs_t r = '0;
        r.busy = 1'b1;
        if (!is_mret && step == 0) begin
            r.set_mepc     = 1'b1;
            r.wdata_mepc   = pc;
            r.set_mcause   = 1'b1;
            r.wdata_mcause = cause;
        end else if (step == (is_mret ? 0 : 1)) begin
            r.get_mstatus   = 1'b1;
            r.set_mstatus   = 1'b1;
            r.wdata_mstatus = ms_after(is_mret, ms);
        end else begin
            r.redirect = 1'b1;
            if (is_mret) begin
                r.get_mepc    = 1'b1;
                r.redirect_pc = mepc;
            end else begin
                r.get_mtvec   = 1'b1;
                r.redirect_pc = mtvec & ~64'h3;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        ecall_i = 1'b1;
        mret_i  = 1'b1;
        pc_i    = {$urandom, $urandom};
        #12;
        n_cmp++;
        if (obs !== '0) begin n_err++; $display("FAIL reset_hold: got %h expected %h", obs, obs_t'('0)); end
        tick();
        ecall_i = 1'b0;
        mret_i  = 1'b0;
        rst     = 1'b1;
        settle();
        e = exp_idle();
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL reset_release: got %h expected %h", obs, e); end
        tick();
    endtask

    task automatic test_ecall();
        pc_i = 64'h8000_0100; rdata_mtvec_i = 64'h8000_0403; rdata_mstatus_i = 64'h8; rdata_mepc_i = '0;
        ecall_i = 1'b1;
        settle();
        e = exp_idle();
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL ecall_idle: got %h expected %h", obs, e); end
        tick();
        ecall_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            settle();
            e = exp_busy(1'b0, s, 64'h8000_0100, ECALL_C, rdata_mtvec_i, rdata_mepc_i, rdata_mstatus_i);
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL ecall_seq step %0d: got %h expected %h", s, obs, e); end
            if (s == 1) begin
                n_cmp++;
                if (wdata_mstatus_o !== 64'h1880) begin n_err++; $display("FAIL ecall_mstatus: got %h expected %h", wdata_mstatus_o, 64'h1880); end
            end
            if (s == 2) begin
                n_cmp++;
                if (redirect_pc_o !== 64'h8000_0400) begin n_err++; $display("FAIL ecall_target: got %h expected %h", redirect_pc_o, 64'h8000_0400); end
            end
            tick();
        end
    endtask

    task automatic test_mret();
        pc_i = 64'h8000_0104; rdata_mepc_i = 64'h8000_0104; rdata_mstatus_i = 64'h1880;
        mret_i = 1'b1;
        settle();
        e = exp_idle();
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL mret_idle: got %h expected %h", obs, e); end
        tick();
        mret_i = 1'b0;
        for (int s = 0; s < 2; s++) begin
            settle();
            e = exp_busy(1'b1, s, pc_i, '0, rdata_mtvec_i, rdata_mepc_i, rdata_mstatus_i);
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL mret_seq step %0d: got %h expected %h", s, obs, e); end
            if (s == 0) begin
                n_cmp++;
                if (wdata_mstatus_o !== 64'h1888) begin n_err++; $display("FAIL mret_mstatus: got %h expected %h", wdata_mstatus_o, 64'h1888); end
            end
            tick();
        end
        settle();
        e = exp_idle();
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL mret_pulse_end: got %h expected %h", obs, e); end
    endtask

    task automatic test_both();
        logic [63:0] pc;
        pc = {$urandom, $urandom};
        pc_i = pc; rdata_mtvec_i = {$urandom, $urandom}; rdata_mepc_i = {$urandom, $urandom};
        rdata_mstatus_i = {$urandom, $urandom} & ~64'h8;
        ecall_i = 1'b1;
        mret_i  = 1'b1;
        settle();
        tick();
        ecall_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            settle();
            e = exp_busy(1'b0, s, pc, ECALL_C, rdata_mtvec_i, rdata_mepc_i, rdata_mstatus_i);
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL both_trap step %0d: got %h expected %h", s, obs, e); end
            tick();
        end
        settle();
        e = exp_idle();
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL both_gap: got %h expected %h", obs, e); end
        tick();
        mret_i = 1'b0;
        for (int s = 0; s < 2; s++) begin
            settle();
            e = exp_busy(1'b1, s, pc, '0, rdata_mtvec_i, rdata_mepc_i, rdata_mstatus_i);
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL both_mret step %0d: got %h expected %h", s, obs, e); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] pc1, pc2;
        pc1 = {$urandom, $urandom};
        pc2 = {$urandom, $urandom};
        rdata_mtvec_i = {$urandom, $urandom}; rdata_mstatus_i = {$urandom, $urandom} & ~64'h8;
        pc_i    = pc1;
        ecall_i = 1'b1;
        settle();
        tick();
        pc_i = pc2;
        for (int s = 0; s < 3; s++) begin
            settle();
            e = exp_busy(1'b0, s, pc1, ECALL_C, rdata_mtvec_i, rdata_mepc_i, rdata_mstatus_i);
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL b2b_first step %0d: got %h expected %h", s, obs, e); end
            tick();
        end
        settle();
        e = exp_idle();
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL b2b_gap: got %h expected %h", obs, e); end
        tick();
        ecall_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            settle();
            e = exp_busy(1'b0, s, pc2, ECALL_C, rdata_mtvec_i, rdata_mepc_i, rdata_mstatus_i);
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL b2b_second step %0d: got %h expected %h", s, obs, e); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        pc_i = {$urandom, $urandom};
        rdata_mtvec_i = {$urandom, $urandom}; rdata_mstatus_i = {$urandom, $urandom} & ~64'h8;
        ecall_i = 1'b1;
        settle();
        tick();
        ecall_i = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        n_cmp++;
        if (obs !== '0) begin n_err++; $display("FAIL rstmid_now: got %h expected %h", obs, obs_t'('0)); end
        tick();
        n_cmp++;
        if (obs !== '0) begin n_err++; $display("FAIL rstmid_hold: got %h expected %h", obs, obs_t'('0)); end
        rst = 1'b1;
        settle();
        for (int s = 0; s < 4; s++) begin
            e = exp_idle();
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL rstmid_after cycle %0d: got %h expected %h", s, obs, e); end
            tick();
        end
    endtask

    task automatic test_random();
        bit          m;
        int          gap;
        logic [63:0] pc;
        for (int t = 0; t < 40; t++) begin
            m   = 1'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                pc_i = {$urandom, $urandom};
                rdata_mstatus_i = {$urandom, $urandom};
                settle();
                e = exp_idle();
                n_cmp++;
                if (obs !== e) begin n_err++; $display("FAIL rand_gap txn %0d: got %h expected %h", t, obs, e); end
                tick();
            end
            pc = {$urandom, $urandom};
            pc_i = pc;
            rdata_mtvec_i = {$urandom, $urandom}; rdata_mepc_i = {$urandom, $urandom};
            rdata_mstatus_i = {$urandom, $urandom};
            ecall_i = !m;
            mret_i  = m;
            settle();
            e = exp_idle();
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL rand_accept txn %0d: got %h expected %h", t, obs, e); end
            tick();
            ecall_i = 1'b0;
            mret_i  = 1'b0;
            pc_i    = {$urandom, $urandom};
            for (int s = 0; s < (m ? 2 : 3); s++) begin
                settle();
                e = exp_busy(m, s, pc, m ? 64'd0 : ECALL_C, rdata_mtvec_i, rdata_mepc_i, rdata_mstatus_i);
                n_cmp++;
                if (obs !== e) begin n_err++; $display("FAIL rand_seq txn %0d step %0d: got %h expected %h", t, s, obs, e); end
                tick();
            end
        end
    endtask

`ifdef YSYX_22040895_TRAP_IRQ_EN
    task automatic test_irq();
        logic [63:0] pc;
        pc = {$urandom, $urandom};
        pc_i = pc;
        rdata_mtvec_i = {$urandom, $urandom};
        rdata_mstatus_i = {$urandom, $urandom} | 64'h8;
        irq_timer_i = 1'b1;
        ecall_i     = 1'b1;
        mret_i      = 1'b1;
        settle();
        tick();
        irq_timer_i = 1'b0;
        ecall_i     = 1'b0;
        for (int s = 0; s < 3; s++) begin
            settle();
            e = exp_busy(1'b0, s, pc, IRQ_CAUSE, rdata_mtvec_i, rdata_mepc_i, rdata_mstatus_i);
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL irq_trap step %0d: got %h expected %h", s, obs, e); end
            tick();
        end
        tick();
        mret_i = 1'b0;
        tick();
        tick();
        rdata_mstatus_i = {$urandom, $urandom} & ~64'h8;
        irq_timer_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            settle();
            e = exp_idle();
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL irq_masked cycle %0d: got %h expected %h", s, obs, e); end
            tick();
        end
        irq_timer_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_ecall();
        test_mret();
        test_both();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef YSYX_22040895_TRAP_IRQ_EN
        test_irq();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
